decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage feeding the execute stage. Accepts 24-bit instructions from fetch over valid/ready.
//  Cracks each one into the execute-stage control bundle and holds it in a one-entry pipeline register.
//  Adds a load-use interlock bubble, drops work on a jump flush, and halts the front end after END.
// PARAMETERS
//  INSTR_W     24  instruction width (fixed encoding below; other values unsupported)
//  REGI_BITS   4   register index width (rd/rsa/rsb)
//  JUMP_BITS   10  jump address width
// PORTS
//  clk_i          in   1   clock
//  rst_i          in   1   reset, asynchronous, active-high
//  instr_i        in   24  instruction from fetch
//  instr_valid_i  in   1   instr_i valid
//  instr_ready_o  out  1   decode accepts instr_i this cycle
//  flush_i        in   1   jump taken in execute; kill held + incoming instruction
//  e_ready_i      in   1   execute consumes output register this cycle
//  valid_o        out  1   output bundle valid
//  rd_o/rsa_o/rsb_o  out  4 each  destination / source register indices
//  cond  aluOpcode  out  2 / 3  condition code / ALU operation
//  enableAluInt/enableAluV/enableMem/enableJump/enableSwap  out  1 each  unit select, one-hot or zero
//  flagEnd/flagNop/flagImm/flagMemRead/flagMemWrite  out  1 each  instruction flags
//  ImmOut  jumpAddress  out  8 / 10  immediate / jump target
//  swapBitOrigin  swapBitDest  out  3 each  swap bit positions
//  halted_o       out  1   END issued; front end stopped
// BEHAVIOUR
//  Encoding: [23:20] class, [19:18] cond, [17:15] aluop, [14:11] rd, [10:7] rsa, [6:3] rsb.
//   Imm forms: [7:0] imm. JUMP: [9:0] addr. SWAP: [13:6] imm, [5:3] origin, [2:0] dest.
//  Classes: 0 NOP, 1 ALU int reg, 2 ALU int imm (flagImm), 3 ALU vec, 4 LOAD (enableMem+flagMemRead),
//   5 STORE (enableMem+flagMemWrite), 6 JUMP, 7 SWAP int, 8 SWAP vec (both enableSwap), F END (flagEnd).
//   9-E illegal; see CONFIGURATION.
//  Unused fields of a class drive 0. Bubble = valid_o=1, flagNop=1, all other bundle outputs 0.
//  Reset: every output 0, FSM=RUN, output register invalid. Reset mid-operation discards everything.
//  Latency: instruction accepted at edge N appears on outputs after edge N (1 cycle).
//  advance = !valid_o || e_ready_i.
//  Interlock: held bundle is LOAD with rd_o == rsa or rsb of a reading instr_i (classes 1,3,5,7,8).
//   Reads rsa only for imm/swap forms.
//  instr_ready_o = (state==RUN) && advance && !interlock && !flush_i.
//  Register update, priority order:
//   1. flush_i: valid_o<=0; instr_i dropped; FSM unchanged (flush in HALT stays HALT).
//   2. !advance: hold all outputs stable.
//   3. interlock: load bubble; instr_i not taken.
//   4. instr_valid_i && instr_ready_o: load decoded bundle.
//   5. else: valid_o<=0.
//  FSM: RUN -> HALT when END accepted (not if flush_i same cycle).
//   HALT: instr_ready_o=0, END held until consumed, then valid_o=0. Exit HALT only via rst_i.
//  halted_o = (state==HALT), set the cycle after END is accepted.
//  One instruction in flight max; no multi-entry buffering.
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN defined: illegal class is accepted.
//   It issues as a bubble, sets sticky illegal_o (extra 1-bit port, reset 0) and FSM -> HALT.
//  Not defined: illegal class decodes as NOP bubble. No illegal_o port. FSM unaffected.
// TESTING
//  instr 0x119228, e_ready_i=1 -> next cycle valid_o=1, enableAluInt=1, aluOpcode=3, rd=2, rsa=4, rsb=5.
//  LOAD rd=3 then ALU reg rsa=3 back-to-back -> 1 bubble cycle (flagNop=1), instr_ready_o=0, then ALU bundle.
//  JUMP addr 0x2A5 -> enableJump=1, jumpAddress=0x2A5; flush_i 1 cycle -> valid_o=0 next, incoming instr dropped.
//  e_ready_i=0 for 3 cycles with bundle held -> outputs bit-stable, instr_ready_o=0; resumes on e_ready_i=1.
//  END (0xF00000) -> flagEnd=1, halted_o=1 next cycle, instr_ready_o=0 forever; rst_i pulse -> RUN, all outputs 0.
//  class 0xA: macro on -> bubble, illegal_o=1, halted_o=1; macro off -> bubble only, decode continues.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch handshake, flush / execute-ready controls and the decoded execute-stage bundle.
// DECODE_ILLEGAL_TRAP_EN adds the sticky illegal_o flag.
interface decode_stage_if #(
   parameter int INSTR_W   = 24,
   parameter int REGI_BITS = 4,
   parameter int JUMP_BITS = 10
);
   logic [INSTR_W-1:0]   instr_i;
   logic                 instr_valid_i;
   logic                 instr_ready_o;
   logic                 flush_i;
   logic                 e_ready_i;
   logic                 valid_o;
   logic [REGI_BITS-1:0] rd_o;
   logic [REGI_BITS-1:0] rsa_o;
   logic [REGI_BITS-1:0] rsb_o;
   logic [1:0]           cond;
   logic [2:0]           aluOpcode;
   logic                 enableAluInt;
   logic                 enableAluV;
   logic                 enableMem;
   logic                 enableJump;
   logic                 enableSwap;
   logic                 flagEnd;
   logic                 flagNop;
   logic                 flagImm;
   logic                 flagMemRead;
   logic                 flagMemWrite;
   logic [7:0]           ImmOut;
   logic [JUMP_BITS-1:0] jumpAddress;
   logic [2:0]           swapBitOrigin;
   logic [2:0]           swapBitDest;
   logic                 halted_o;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic                 illegal_o;

   modport master (
      output instr_i, instr_valid_i, flush_i, e_ready_i,
      input  instr_ready_o, valid_o, rd_o, rsa_o, rsb_o, cond, aluOpcode,
             enableAluInt, enableAluV, enableMem, enableJump, enableSwap,
             flagEnd, flagNop, flagImm, flagMemRead, flagMemWrite,
             ImmOut, jumpAddress, swapBitOrigin, swapBitDest, halted_o, illegal_o
   );
   modport slave (
      input  instr_i, instr_valid_i, flush_i, e_ready_i,
      output instr_ready_o, valid_o, rd_o, rsa_o, rsb_o, cond, aluOpcode,
             enableAluInt, enableAluV, enableMem, enableJump, enableSwap,
             flagEnd, flagNop, flagImm, flagMemRead, flagMemWrite,
             ImmOut, jumpAddress, swapBitOrigin, swapBitDest, halted_o, illegal_o
   );
`else
   modport master (
      output instr_i, instr_valid_i, flush_i, e_ready_i,
      input  instr_ready_o, valid_o, rd_o, rsa_o, rsb_o, cond, aluOpcode,
             enableAluInt, enableAluV, enableMem, enableJump, enableSwap,
             flagEnd, flagNop, flagImm, flagMemRead, flagMemWrite,
             ImmOut, jumpAddress, swapBitOrigin, swapBitDest, halted_o
   );
   modport slave (
      input  instr_i, instr_valid_i, flush_i, e_ready_i,
      output instr_ready_o, valid_o, rd_o, rsa_o, rsb_o, cond, aluOpcode,
             enableAluInt, enableAluV, enableMem, enableJump, enableSwap,
             flagEnd, flagNop, flagImm, flagMemRead, flagMemWrite,
             ImmOut, jumpAddress, swapBitOrigin, swapBitDest, halted_o
   );
`endif
endinterface

// File: rtl/decode_stage.sv
// Decode stage: cracks 24-bit fetch instructions into the execute control bundle (one-entry register).
// Optional DECODE_ILLEGAL_TRAP_EN: illegal classes issue a bubble, raise sticky illegal_o and halt.
module decode_stage #(
   parameter int INSTR_W   = 24,
   parameter int REGI_BITS = 4,
   parameter int JUMP_BITS = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   decode_stage_if.slave bus
);
   typedef struct packed {
      logic                 valid;
      logic [REGI_BITS-1:0] rd;
      logic [REGI_BITS-1:0] rsa;
      logic [REGI_BITS-1:0] rsb;
      logic [1:0]           cond;
      logic [2:0]           alu_op;
      logic                 en_alu_int;
      logic                 en_alu_v;
      logic                 en_mem;
      logic                 en_jump;
      logic                 en_swap;
      logic                 f_end;
      logic                 f_nop;
      logic                 f_imm;
      logic                 f_mem_read;
      logic                 f_mem_write;
      logic [7:0]           imm;
      logic [JUMP_BITS-1:0] jump_addr;
      logic [2:0]           swap_org;
      logic [2:0]           swap_dst;
   } bundle_t;

   typedef enum logic {RUN, HALT} state_t;

   state_t  state_reg;
   bundle_t bundle_reg;
   bundle_t dec_next;
   bundle_t bubble;
   logic [3:0] cls;
   logic reads_rsa, reads_rsb;
   logic advance, held_load, interlock, accept;

   assign cls = bus.instr_i[INSTR_W-1 -: 4];

   always_comb begin
      dec_next       = '0;
      dec_next.valid = 1'b1;
      reads_rsa      = 1'b0;
      reads_rsb      = 1'b0;
      case (cls)
         4'h1, 4'h3: begin
            dec_next.en_alu_int = (cls == 4'h1);
            dec_next.en_alu_v   = (cls == 4'h3);
            dec_next.cond       = bus.instr_i[19:18];
            dec_next.alu_op     = bus.instr_i[17:15];
            dec_next.rd         = bus.instr_i[14:11];
            dec_next.rsa        = bus.instr_i[10:7];
            dec_next.rsb        = bus.instr_i[6:3];
            reads_rsa           = 1'b1;
            reads_rsb           = 1'b1;
         end
         4'h2: begin
            dec_next.en_alu_int = 1'b1;
            dec_next.f_imm      = 1'b1;
            dec_next.cond       = bus.instr_i[19:18];
            dec_next.alu_op     = bus.instr_i[17:15];
            dec_next.rd         = bus.instr_i[14:11];
            dec_next.rsa        = bus.instr_i[10:7];
            dec_next.imm        = bus.instr_i[7:0];
         end
         4'h4, 4'h5: begin
            dec_next.en_mem      = 1'b1;
            dec_next.f_mem_read  = (cls == 4'h4);
            dec_next.f_mem_write = (cls == 4'h5);
            dec_next.cond        = bus.instr_i[19:18];
            dec_next.rd          = bus.instr_i[14:11];
            dec_next.rsa         = bus.instr_i[10:7];
            dec_next.imm         = bus.instr_i[7:0];
            reads_rsa            = (cls == 4'h5);
         end
         4'h6: begin
            dec_next.en_jump   = 1'b1;
            dec_next.cond      = bus.instr_i[19:18];
            dec_next.jump_addr = bus.instr_i[JUMP_BITS-1:0];
         end
         4'h7, 4'h8: begin
            dec_next.en_swap  = 1'b1;
            dec_next.cond     = bus.instr_i[19:18];
            dec_next.rd       = bus.instr_i[14:11];
            dec_next.rsa      = bus.instr_i[10:7];
            dec_next.imm      = bus.instr_i[13:6];
            dec_next.swap_org = bus.instr_i[5:3];
            dec_next.swap_dst = bus.instr_i[2:0];
            reads_rsa         = 1'b1;
         end
         4'hF:    dec_next.f_end = 1'b1;
         // NOP and the illegal classes both decode to a bubble
         default: dec_next.f_nop = 1'b1;
      endcase
   end

   always_comb begin
      bubble       = '0;
      bubble.valid = 1'b1;
      bubble.f_nop = 1'b1;
   end

   assign advance   = !bundle_reg.valid || bus.e_ready_i;
   assign held_load = bundle_reg.valid && bundle_reg.en_mem && bundle_reg.f_mem_read;
   assign interlock = (state_reg == RUN) && held_load && bus.instr_valid_i &&
                      ((reads_rsa && (bundle_reg.rd == bus.instr_i[10:7])) ||
                       (reads_rsb && (bundle_reg.rd == bus.instr_i[6:3])));
   assign bus.instr_ready_o = (state_reg == RUN) && advance && !interlock && !bus.flush_i;
   assign accept = bus.instr_valid_i && bus.instr_ready_o;

`ifdef DECODE_ILLEGAL_TRAP_EN
   logic illegal_reg;
   logic is_illegal;
   assign is_illegal    = (cls >= 4'h9) && (cls <= 4'hE);
   assign bus.illegal_o = illegal_reg;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg  <= RUN;
         bundle_reg <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
         illegal_reg <= 1'b0;
`endif
      end else if (bus.flush_i) begin
         bundle_reg <= '0;
      end else if (advance) begin
         if (interlock) begin
            bundle_reg <= bubble;
         end else if (accept) begin
            bundle_reg <= dec_next;
            if (dec_next.f_end)
               state_reg <= HALT;
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (is_illegal) begin
               state_reg   <= HALT;
               illegal_reg <= 1'b1;
            end
`endif
         end else begin
            bundle_reg <= '0;
         end
      end
   end

   assign bus.valid_o       = bundle_reg.valid;
   assign bus.rd_o          = bundle_reg.rd;
   assign bus.rsa_o         = bundle_reg.rsa;
   assign bus.rsb_o         = bundle_reg.rsb;
   assign bus.cond          = bundle_reg.cond;
   assign bus.aluOpcode     = bundle_reg.alu_op;
   assign bus.enableAluInt  = bundle_reg.en_alu_int;
   assign bus.enableAluV    = bundle_reg.en_alu_v;
   assign bus.enableMem     = bundle_reg.en_mem;
   assign bus.enableJump    = bundle_reg.en_jump;
   assign bus.enableSwap    = bundle_reg.en_swap;
   assign bus.flagEnd       = bundle_reg.f_end;
   assign bus.flagNop       = bundle_reg.f_nop;
   assign bus.flagImm       = bundle_reg.f_imm;
   assign bus.flagMemRead   = bundle_reg.f_mem_read;
   assign bus.flagMemWrite  = bundle_reg.f_mem_write;
   assign bus.ImmOut        = bundle_reg.imm;
   assign bus.jumpAddress   = bundle_reg.jump_addr;
   assign bus.swapBitOrigin = bundle_reg.swap_org;
   assign bus.swapBitDest   = bundle_reg.swap_dst;
   assign bus.halted_o      = (state_reg == HALT);
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, load-use bubble, flush, stall, END halt, illegal class.
// Build with DECODE_ILLEGAL_TRAP_EN defined to exercise the trap variant.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;

   decode_stage_if bus ();
   decode_stage dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   always #5 clk = ~clk;

   wire [51:0] outs = {bus.valid_o, bus.rd_o, bus.rsa_o, bus.rsb_o, bus.cond, bus.aluOpcode,
                       bus.enableAluInt, bus.enableAluV, bus.enableMem, bus.enableJump,
                       bus.enableSwap, bus.flagEnd, bus.flagNop, bus.flagImm, bus.flagMemRead,
                       bus.flagMemWrite, bus.ImmOut, bus.jumpAddress, bus.swapBitOrigin,
                       bus.swapBitDest};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [23:0] ins, input logic er, input logic fl);
      bus.instr_valid_i = v;
      bus.instr_i       = ins;
      bus.e_ready_i     = er;
      bus.flush_i       = fl;
      #1;
   endtask

   initial begin
      drive(1'b0, 24'h0, 1'b1, 1'b0);
      tick();
      // reset state
      chk("rst_outs", outs, 0);
      chk("rst_halted", bus.halted_o, 0);
      chk("rst_ready", bus.instr_ready_o, 1);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("rst_illegal", bus.illegal_o, 0);
`endif
      rst = 1'b0;

      // ALU int reg 0x119228
      drive(1'b1, 24'h119228, 1'b1, 1'b0);
      chk("alu_ready", bus.instr_ready_o, 1);
      tick();
      chk("alu_valid", bus.valid_o, 1);
      chk("alu_en", bus.enableAluInt, 1);
      chk("alu_op", bus.aluOpcode, 3);
      chk("alu_rd", bus.rd_o, 2);
      chk("alu_rsa", bus.rsa_o, 4);
      chk("alu_rsb", bus.rsb_o, 5);
      chk("alu_imm", bus.ImmOut, 0);

      // LOAD rd=3 rsa=1 imm=A5, then ALU reading r3 -> one bubble
      drive(1'b1, 24'h4018A5, 1'b1, 1'b0);
      tick();
      chk("ld_mem", bus.enableMem, 1);
      chk("ld_rd", bus.flagMemRead, 1);
      chk("ld_rdi", bus.rd_o, 3);
      chk("ld_rsa", bus.rsa_o, 1);
      chk("ld_imm", bus.ImmOut, 8'hA5);
      drive(1'b1, 24'h16B9C8, 1'b1, 1'b0);
      chk("il_ready", bus.instr_ready_o, 0);
      tick();
      chk("bub_valid", bus.valid_o, 1);
      chk("bub_nop", bus.flagNop, 1);
      chk("bub_mem", bus.enableMem, 0);
      chk("bub_rd", bus.rd_o, 0);
      chk("il_ready2", bus.instr_ready_o, 1);
      tick();
      chk("alu2_en", bus.enableAluInt, 1);
      chk("alu2_cond", bus.cond, 1);
      chk("alu2_op", bus.aluOpcode, 5);
      chk("alu2_rd", bus.rd_o, 7);
      chk("alu2_rsa", bus.rsa_o, 3);
      chk("alu2_rsb", bus.rsb_o, 9);
      chk("alu2_nop", bus.flagNop, 0);

      // JUMP 0x2A5, then flush kills it and the incoming instruction
      drive(1'b1, 24'h6002A5, 1'b1, 1'b0);
      tick();
      chk("jmp_en", bus.enableJump, 1);
      chk("jmp_addr", bus.jumpAddress, 10'h2A5);
      chk("jmp_rsa", bus.rsa_o, 0);
      chk("jmp_imm", bus.ImmOut, 0);
      drive(1'b1, 24'h119228, 1'b1, 1'b1);
      chk("fl_ready", bus.instr_ready_o, 0);
      tick();
      chk("fl_valid", bus.valid_o, 0);
      chk("fl_jmp", bus.enableJump, 0);
      drive(1'b0, 24'h0, 1'b1, 1'b0);
      tick();
      chk("fl_drop", bus.valid_o, 0);
      chk("fl_drop_alu", bus.enableAluInt, 0);

      // stall: ALU held for 3 cycles while execute is not ready
      drive(1'b1, 24'h119228, 1'b1, 1'b0);
      tick();
      drive(1'b1, 24'h4018A5, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("st_ready", bus.instr_ready_o, 0);
         tick();
         chk("st_valid", bus.valid_o, 1);
         chk("st_en", bus.enableAluInt, 1);
         chk("st_rd", bus.rd_o, 2);
         chk("st_op", bus.aluOpcode, 3);
         chk("st_mem", bus.enableMem, 0);
      end
      drive(1'b1, 24'h4018A5, 1'b1, 1'b0);
      chk("st_resume", bus.instr_ready_o, 1);
      tick();
      chk("st_ld_mem", bus.enableMem, 1);
      chk("st_ld_rd", bus.rd_o, 3);

      // SWAP int 0x78171E
      drive(1'b1, 24'h78171E, 1'b1, 1'b0);
      tick();
      chk("sw_en", bus.enableSwap, 1);
      chk("sw_cond", bus.cond, 2);
      chk("sw_imm", bus.ImmOut, 8'h5C);
      chk("sw_org", bus.swapBitOrigin, 3);
      chk("sw_dst", bus.swapBitDest, 6);
      chk("sw_rd", bus.rd_o, 2);
      chk("sw_rsa", bus.rsa_o, 14);
      chk("sw_rsb", bus.rsb_o, 0);
      chk("sw_op", bus.aluOpcode, 0);

      // END halts the front end until reset
      drive(1'b1, 24'hF00000, 1'b1, 1'b0);
      chk("end_ready", bus.instr_ready_o, 1);
      tick();
      chk("end_flag", bus.flagEnd, 1);
      chk("end_valid", bus.valid_o, 1);
      chk("end_halted", bus.halted_o, 1);
      drive(1'b1, 24'h119228, 1'b0, 1'b0);
      chk("h_ready0", bus.instr_ready_o, 0);
      tick();
      chk("h_hold", bus.flagEnd, 1);
      drive(1'b1, 24'h119228, 1'b1, 1'b0);
      chk("h_ready1", bus.instr_ready_o, 0);
      tick();
      chk("h_valid", bus.valid_o, 0);
      chk("h_flag", bus.flagEnd, 0);
      chk("h_halted", bus.halted_o, 1);
      chk("h_ready2", bus.instr_ready_o, 0);
      tick();
      chk("h_valid2", bus.valid_o, 0);
      chk("h_ready3", bus.instr_ready_o, 0);
      rst = 1'b1;
      drive(1'b0, 24'h0, 1'b1, 1'b0);
      chk("r_outs", outs, 0);
      chk("r_halted", bus.halted_o, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("r_ready", bus.instr_ready_o, 1);

      // illegal class 0xA
      drive(1'b1, 24'hA00000, 1'b1, 1'b0);
      chk("ill_ready", bus.instr_ready_o, 1);
      tick();
      chk("ill_valid", bus.valid_o, 1);
      chk("ill_nop", bus.flagNop, 1);
      chk("ill_alu", bus.enableAluInt, 0);
      drive(1'b1, 24'h119228, 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("ill_flag", bus.illegal_o, 1);
      chk("ill_halted", bus.halted_o, 1);
      chk("ill_ready2", bus.instr_ready_o, 0);
      tick();
      chk("ill_sticky", bus.illegal_o, 1);
      chk("ill_after", bus.valid_o, 0);
`else
      chk("ill_halted", bus.halted_o, 0);
      chk("ill_ready2", bus.instr_ready_o, 1);
      tick();
      chk("ill_next", bus.enableAluInt, 1);
      chk("ill_next_rd", bus.rd_o, 2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
